// File: rtl/alu_pkg.sv
// Shared opcode encoding, flag bundle and pipeline depth for the ALU pipe.
package alu_pkg;

  // Pipeline depth: execute register (E) then output register (O).
  localparam int STAGES = 2;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_ADC = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic c;  // carry / no-borrow / last bit shifted out
    logic z;  // result is zero
    logic o;  // signed overflow (arithmetic ops only)
    logic n;  // result MSB
  } alu_flags_t;

  // Only the adder ops write the carry register; logic and shift ops keep it.
  function automatic logic op_sets_carry(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADC);
  endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Valid/ready request and result bus of the ALU pipe.
interface alu_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [2:0]       sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             flag_c;
  logic             flag_z;
  logic             flag_o;
  logic             flag_n;

  // Producer/consumer side (drives operations, accepts results).
  modport master (
    output in_valid, opA, opB, sel, out_ready,
    input  in_ready, out_valid, res, flag_c, flag_z, flag_o, flag_n
  );

  // ALU side.
  modport slave (
    input  in_valid, opA, opB, sel, out_ready,
    output in_ready, out_valid, res, flag_c, flag_z, flag_o, flag_n
  );
endinterface

// File: rtl/alu_core.sv
// Combinational ALU datapath: result and carry/zero/overflow/negative flags.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_sel,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_res,
  output alu_flags_t       o_flg
);

  localparam logic [WIDTH-1:0] W_LIM = WIDTH'(WIDTH);

  logic [WIDTH-1:0] w_b;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic             w_ovf;
  logic [SHW-1:0]   w_amt;
  logic [WIDTH:0]   w_shl;
  logic [WIDTH:0]   w_shr;
  logic             w_sh_zero;
  logic             w_sh_big;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_o;

  // One shared adder: SUB is A + ~B + 1, ADC feeds the stored carry.
  always_comb begin
    w_b   = i_b;
    w_cin = 1'b0;
    case (i_sel)
      OP_SUB:  begin w_b = ~i_b; w_cin = 1'b1; end
      OP_ADC:  w_cin = i_cin;
      default: ;
    endcase
  end

  assign w_sum = {1'b0, i_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_cin};
  // Overflow: both addends share a sign that the sum does not.
  assign w_ovf = (i_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);

  // Shifts carry one guard bit so the last bit shifted out falls into it.
  assign w_sh_zero = (i_b == '0);
  assign w_sh_big  = (i_b >= W_LIM);
  assign w_amt     = i_b[SHW-1:0];
  assign w_shl     = {1'b0, i_a} << w_amt;
  assign w_shr     = {i_a, 1'b0} >> w_amt;

  // Result and carry selection per opcode.
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_o   = 1'b0;
    case (i_sel)
      OP_ADD, OP_SUB, OP_ADC: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_o   = w_ovf;
      end
      OP_AND: w_res = i_a & i_b;
      OP_OR:  w_res = i_a | i_b;
      OP_XOR: w_res = i_a ^ i_b;
      OP_SHL: begin
        if (w_sh_zero) begin
          w_res = i_a;
        end else if (!w_sh_big) begin
          w_res = w_shl[WIDTH-1:0];
          w_c   = w_shl[WIDTH];
        end
      end
      OP_SHR: begin
        if (w_sh_zero) begin
          w_res = i_a;
        end else if (!w_sh_big) begin
          w_res = w_shr[WIDTH:1];
          w_c   = w_shr[0];
        end
      end
      default: ;
    endcase
  end

  assign o_res = w_res;
  assign o_flg = '{c: w_c, z: (w_res == '0), o: w_o, n: w_res[WIDTH-1]};

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipe: compute into E on accept, E moves to O.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic       clk,
  input  logic       rst,
  alu_pipe_if.slave  bus
);

  // Bit 1 = E holds an op, bit STAGES = O holds a result.
  logic [STAGES:1]  r_vld_pipe;
  logic [WIDTH-1:0] r_e_res;
  alu_flags_t       r_e_flg;
  logic [WIDTH-1:0] r_o_res;
  alu_flags_t       r_o_flg;
  logic             r_carry;

  logic [WIDTH-1:0] w_res;
  alu_flags_t       w_flg;
  logic             w_in_ready;
  logic             w_fire;

  alu_core #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_core (
    .i_a   (bus.opA),
    .i_b   (bus.opB),
    .i_sel (bus.sel),
    .i_cin (r_carry),
    .o_res (w_res),
    .o_flg (w_flg)
  );

  // Whole pipe advances unless a result sits in O unclaimed.
  assign w_in_ready = !(r_vld_pipe[STAGES] && !bus.out_ready);
  assign w_fire     = bus.in_valid && w_in_ready;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_vld_pipe[STAGES];
  assign bus.res       = r_o_res;
  assign bus.flag_c    = r_o_flg.c;
  assign bus.flag_z    = r_o_flg.z;
  assign bus.flag_o    = r_o_flg.o;
  assign bus.flag_n    = r_o_flg.n;

  // Pipe registers plus carry; the carry is written at accept time so a
  // following ADC already sees it without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_e_res    <= '0;
      r_e_flg    <= '0;
      r_o_res    <= '0;
      r_o_flg    <= '0;
      r_carry    <= 1'b0;
    end else if (w_in_ready) begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], w_fire};
      r_o_res    <= r_e_res;
      r_o_flg    <= r_e_flg;
      if (w_fire) begin
        r_e_res <= w_res;
        r_e_flg <= w_flg;
        if (op_sets_carry(bus.sel)) r_carry <= w_flg.c;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed corner ops, stall/reset sequences, random traffic
// scored against an arithmetic reference model.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W = 16;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  flg;  // {c, z, o, n}
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_err  = 0;
  int   n_pops = 0;
  exp_t exp_q[$];
  bit   m_carry = 1'b0;

  alu_pipe_if #(.WIDTH(W)) bus();

  alu_pipe #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  // Reference behaviour from plain integer arithmetic.
  function automatic exp_t ref_alu(input int unsigned a, input int unsigned b,
                                   input int unsigned s, input bit cin);
    exp_t        e;
    int unsigned r = 0;
    int unsigned u;
    int          sa, sb, sr;
    bit          c = 1'b0;
    bit          o = 1'b0;
    sa = (a >= 32768) ? int'(a) - 65536 : int'(a);
    sb = (b >= 32768) ? int'(b) - 65536 : int'(b);
    case (s)
      0, 7: begin
        u  = a + b + ((s == 7) ? int'(cin) : 0);
        c  = (u >= 65536);
        r  = u % 65536;
        sr = sa + sb + ((s == 7) ? int'(cin) : 0);
        o  = (sr > 32767) || (sr < -32768);
      end
      1: begin
        r  = (a + 65536 - b) % 65536;
        c  = (a >= b);
        sr = sa - sb;
        o  = (sr > 32767) || (sr < -32768);
      end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin
        if (b == 0) r = a;
        else if (b < 16) begin
          r = (a << b) % 65536;
          c = ((a >> (16 - b)) & 1) == 1;
        end
      end
      6: begin
        if (b == 0) r = a;
        else if (b < 16) begin
          r = a >> b;
          c = ((a >> (b - 1)) & 1) == 1;
        end
      end
      default: ;
    endcase
    e.res = r[15:0];
    e.flg = {c, (r == 0), o, r[15]};
    return e;
  endfunction

  function automatic logic [15:0] rnd_val();
    case ($urandom_range(5))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'hFFFF;
      3:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  // Scoreboard: observe handshakes between edges, predict at accept, compare at delivery.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
      m_carry = 1'b0;
    end else begin
      chk("in_ready_rule", bus.in_ready, !(bus.out_valid && !bus.out_ready));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_res", bus.res, e.res);
          chk("sb_flg", {bus.flag_c, bus.flag_z, bus.flag_o, bus.flag_n}, e.flg);
          n_pops++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        e = ref_alu(bus.opA, bus.opB, bus.sel, m_carry);
        exp_q.push_back(e);
        if (bus.sel == OP_ADD || bus.sel == OP_SUB || bus.sel == OP_ADC) m_carry = e.flg[3];
      end
    end
  end

  task automatic drive(input bit v, input logic [15:0] a, input logic [15:0] b, input logic [2:0] s);
    bus.in_valid = v;
    bus.opA      = a;
    bus.opB      = b;
    bus.sel      = s;
  endtask

  // Single op with out_ready high: result must be visible one edge after the accept edge.
  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] s, input logic [15:0] er, input logic [3:0] ef);
    drive(1'b1, a, b, s);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_vld"}, bus.out_valid, 1);
    chk({tag, "_res"}, bus.res, er);
    chk({tag, "_flg"}, {bus.flag_c, bus.flag_z, bus.flag_o, bus.flag_n}, ef);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] st_a[4] = '{16'h1234, 16'hFFFF, 16'h00F0, 16'h8000};
    logic [15:0] st_b[4] = '{16'hF000, 16'h0001, 16'h0F0F, 16'h0004};
    logic [2:0]  st_s[4] = '{OP_ADD, OP_ADC, OP_XOR, OP_SHR};
    int sent, cyc, stall, stall_seen, base;
    bit stall_done;
    logic [2:0]  s;
    logic [15:0] a, b;

    drive(1'b0, '0, '0, '0);
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_vld", bus.out_valid, 0);
    chk("rst_rdy", bus.in_ready, 1);
    chk("rst_res", bus.res, 0);
    chk("rst_flg", {bus.flag_c, bus.flag_z, bus.flag_o, bus.flag_n}, 0);

    // Directed corner operations, flags as {c,z,o,n}.
    do_op("add_ovf", 16'h7FFF, 16'h000A, OP_ADD, 16'h8009, 4'b0011);
    do_op("add_cz",  16'h8000, 16'h8000, OP_ADD, 16'h0000, 4'b1110);
    do_op("adc_cin", 16'h0000, 16'h0000, OP_ADC, 16'h0001, 4'b0000);
    do_op("sub_pos", 16'h000F, 16'h0003, OP_SUB, 16'h000C, 4'b1000);
    do_op("sub_ovf", 16'h8000, 16'h0001, OP_SUB, 16'h7FFF, 4'b1010);
    do_op("shl_c",   16'h8001, 16'h0001, OP_SHL, 16'h0002, 4'b1000);
    do_op("shr_big", 16'h0003, 16'h0011, OP_SHR, 16'h0000, 4'b0100);

    // Reset right after an accept (which set carry): the op vanishes and carry clears.
    drive(1'b1, 16'hFFFF, 16'h0001, OP_ADD);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(1'b1, 16'h0005, 16'h0005, OP_ADD);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b0, '0, '0, '0);
    chk("rr_vld", bus.out_valid, 0);
    chk("rr_rdy", bus.in_ready, 1);
    chk("rr_res", bus.res, 0);
    chk("rr_flg", {bus.flag_c, bus.flag_z, bus.flag_o, bus.flag_n}, 0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("rr_quiet", bus.out_valid, 0);
    end
    do_op("rr_adc", 16'h0001, 16'h0001, OP_ADC, 16'h0002, 4'b0000);

    // Stream of 4 ops with a 3-cycle consumer stall after the first result.
    sent = 0; cyc = 0; stall = 0; stall_seen = 0; stall_done = 1'b0; base = n_pops;
    while ((n_pops - base) < 4 && cyc < 40) begin
      if (sent < 4) drive(1'b1, st_a[sent], st_b[sent], st_s[sent]);
      else          drive(1'b0, '0, '0, '0);
      if (!stall_done && bus.out_valid) begin
        stall = 3;
        stall_done = 1'b1;
      end
      bus.out_ready = (stall == 0);
      if (stall > 0) stall--;
      #1;
      if (!bus.out_ready) begin
        chk("stall_rdy", bus.in_ready, 0);
        if (!bus.in_ready) stall_seen++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    drive(1'b0, '0, '0, '0);
    bus.out_ready = 1'b1;
    chk("stream_cnt", n_pops - base, 4);
    chk("stream_sent", sent, 4);
    chk("stall_cycles", stall_seen, 3);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(99) == 0);
      s = 3'($urandom_range(7));
      a = rnd_val();
      b = (s >= 3'd5 && s != 3'd7) ? 16'($urandom_range(20)) : rnd_val();
      drive($urandom_range(9) < 7, a, b, s);
      bus.out_ready = ($urandom_range(9) < 7);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    drive(1'b0, '0, '0, '0);
    bus.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_vld", bus.out_valid, 0);
    chk("pops_seen", n_pops > 20, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width (legal >= 4).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), the low opB bits that hold the shift amount.
REQ-003 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous reset, active-high.
REQ-005 Port: in_valid  input  1  operation presented.
REQ-006 Port: in_ready  output  1  block can accept an operation this cycle.
REQ-007 Port: opA  input  WIDTH  operand A.
REQ-008 Port: opB  input  WIDTH  operand B / shift amount.
REQ-009 Port: sel  input  3  opcode.
REQ-010 Port: out_valid  output  1  result registers hold a valid result.
REQ-011 Port: out_ready  input  1  consumer accepts the result.
REQ-012 Port: res  output  WIDTH  result.
REQ-013 Port: flag_c, flag_z, flag_o, flag_n  output  1 each  carry, zero, signed overflow, negative.

Function
REQ-014 Opcodes SHALL be: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 ADC (opA+opB+carry register).
REQ-015 Transfer in SHALL occur on a rising edge where in_valid && in_ready; transfer out where out_valid && out_ready.
REQ-016 Pipeline SHALL be 2 stages: execute register (E) loaded on transfer in, output register (O) loaded from E; result of an operation accepted at edge N SHALL appear with out_valid=1 after edge N+1.
REQ-017 in_ready SHALL equal !(out_valid && !out_ready); when in_ready=0 both E and O SHALL hold (global stall), no operation lost or duplicated.
REQ-018 Back-to-back operations with out_ready=1 SHALL sustain one result per cycle.
REQ-019 ADD/ADC: flag_c = carry out of bit WIDTH-1; SUB computed as opA + ~opB + 1, flag_c = that carry out (1 = no borrow).
REQ-020 flag_o SHALL be signed two's-complement overflow for ADD/SUB/ADC, 0 for all other ops.
REQ-021 flag_z = (res == 0); flag_n = res[WIDTH-1], for every op.
REQ-022 AND/OR/XOR: flag_c = 0.
REQ-023 SHL/SHR: amount = opB unsigned; amount 0 -> res=opA, flag_c=0; 1..WIDTH-1 -> flag_c = last bit shifted out; amount >= WIDTH -> res=0, flag_c=0.
REQ-024 Carry register SHALL update with flag_c of each ADD/SUB/ADC at the edge it enters E; ADC reads the value after all earlier accepted ops, so consecutive ADD then ADC chain correctly with no bubble.
REQ-025 Non-arithmetic ops SHALL leave the carry register unchanged.
REQ-026 Simultaneous out transfer and in transfer in the same cycle SHALL both complete.

Reset
REQ-027 On rst=1 at an edge: E and O valid bits, carry register, res and all flags SHALL become 0; in_ready SHALL read 1 the cycle after.
REQ-028 Reset mid-operation SHALL discard in-flight operations; no out_valid pulse for them afterward.
REQ-029 in_valid asserted during rst SHALL be ignored.

Structure
REQ-030 Opcode constants (OP_ADD..OP_ADC) SHALL live in shared package alu_pkg.
REQ-031 Combinational datapath (result + 4 flags from opA, opB, sel, carry_in) SHALL be sub-module alu_core, parameterised by WIDTH; alu_pipe holds registers and handshake.

Verification (WIDTH=16)
REQ-032 ADD 32767+10, out_ready=1 -> 2 cycles later res=0x8009, c=0, o=1, n=1, z=0.
REQ-033 ADD 0x8000+0x8000 -> res=0x0000, c=1, z=1, o=1, n=0; then ADC 0+0 -> res=0x0001, c=0.
REQ-034 SUB 15-3 -> res=12, c=1, o=0; SUB 0x8000-1 -> res=0x7FFF, o=1.
REQ-035 SHL 0x8001 by 1 -> res=0x0002, c=1; SHR 0x0003 by 17 -> res=0, c=0, z=1.
REQ-036 Stream 4 ops, out_ready=0 for 3 cycles after first result -> in_ready=0 while stalled, all 4 results delivered in order, none dropped.
REQ-037 Accept ADD, assert rst next cycle -> out_valid stays 0, carry register 0, subsequent ADC 1+1 -> res=2.
